// File: rtl/write_vec.sv
// write_vec: packs a UART byte stream into 16-bit elements and writes one
// full vector into bank A or bank B, starting at address 0.
//
// Parameters
//   N_ELEM : number of 16-bit elements per vector
//   ADDR_W : write address width (2**ADDR_W >= N_ELEM)
//
// Ports
//   clk      : system clock, rising edge
//   reset    : asynchronous active-high reset
//   start    : one-cycle load request, honoured only while idle
//   bank_sel : target bank latched on start (1 = bank A, 0 = bank B)
//   rx_data  : received byte, qualified by rx_valid
//   rx_valid : one-cycle strobe per received byte
//   we_A     : registered write enable, bank A
//   we_B     : registered write enable, bank B
//   addr     : registered write address (holds between writes)
//   wdata    : registered write data (holds between writes)
//   busy     : high while a load is in progress
//   done     : one-cycle pulse after the final element is written
module write_vec #(
   parameter int N_ELEM = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              bank_sel,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              we_A,
   output logic              we_B,
   output logic [ADDR_W-1:0] addr,
   output logic [15:0]       wdata,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_LO,
      WAIT_HI,
      FINISH
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ELEM - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [7:0]          lo_q, lo_d;
   logic                bank_q, bank_d;
   logic                we_A_q, we_A_d;
   logic                we_B_q, we_B_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [15:0]         wdata_q, wdata_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         lo_q    <= '0;
         bank_q  <= 1'b0;
         we_A_q  <= 1'b0;
         we_B_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lo_q    <= lo_d;
         bank_q  <= bank_d;
         we_A_q  <= we_A_d;
         we_B_q  <= we_B_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lo_d    = lo_q;
      bank_d  = bank_q;
      we_A_d  = 1'b0;
      we_B_d  = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Bytes arriving while idle are dropped on purpose.
            if (start) begin
               bank_d  = bank_sel;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = WAIT_LO;
            end
         end
         WAIT_LO: begin
            if (rx_valid) begin
               lo_d    = rx_data;
               state_d = WAIT_HI;
            end
         end
         WAIT_HI: begin
            // High byte completes the element: write is issued on this edge,
            // so WAIT_LO can take the next byte on the very next cycle.
            if (rx_valid) begin
               wdata_d = {rx_data, lo_q};
               addr_d  = cnt_q;
               we_A_d  = bank_q;
               we_B_d  = ~bank_q;
               if (cnt_q == LAST_IDX) begin
                  state_d = FINISH;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = WAIT_LO;
               end
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign we_A  = we_A_q;
   assign we_B  = we_B_q;
   assign addr  = addr_q;
   assign wdata = wdata_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_write_vec.sv
// Testbench for write_vec: expected writes are queued by the stimulus side
// from the byte stream it sends; a negedge monitor pops and compares every
// write and checks done/busy timing after the final element.
module tb_write_vec;

   localparam int N  = 4;
   localparam int AW = 2;

   logic          clk;
   logic          clk_en;
   logic          reset;
   logic          start;
   logic          bank_sel;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          we_A;
   logic          we_B;
   logic [AW-1:0] addr;
   logic [15:0]   wdata;
   logic          busy;
   logic          done;

   write_vec #(.N_ELEM(N), .ADDR_W(AW)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .bank_sel (bank_sel),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .we_A     (we_A),
      .we_B     (we_B),
      .addr     (addr),
      .wdata    (wdata),
      .busy     (busy),
      .done     (done)
   );

   typedef struct {
      bit          bank;
      int          a;
      logic [15:0] d;
      bit          last;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   bit   pend_done = 0;

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: outputs settle after posedge, so sample on negedge.
   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         if (we_A && we_B) chk("we_both_high", 1, 0);
         if (pend_done) begin
            chk("done_after_last_we", done, 1);
            chk("busy_low_with_done", busy, 0);
            pend_done = 0;
         end else if (done) begin
            chk("unexpected_done", done, 0);
         end
         if (we_A || we_B) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", {we_A, we_B}, 2'b00);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("write_bank", {we_A, we_B}, e.bank ? 2'b10 : 2'b01);
               chk("write_addr", addr, e.a);
               chk("write_data", wdata, e.d);
               if (e.last) pend_done = 1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sends one load of n_send elements (n_send <= N). Expected writes are
   // derived from the byte list: element i = {byte[2i+1], byte[2i]} at addr i.
   // gap_max adds idle cycles between bytes; abuse pulses start/bank_sel
   // during the load and strobes rx_valid in the two cycles after it.
   task automatic load(input bit bank, input logic [7:0] b[2*N], input int n_send,
                       input int gap_max, input bit abuse);
      for (int i = 0; i < n_send; i++) begin
         exp_t e;
         e.bank = bank;
         e.a    = i;
         e.d    = {b[2*i+1], b[2*i]};
         e.last = (i == N - 1);
         exp_q.push_back(e);
      end
      start    = 1'b1;
      bank_sel = bank;
      tick();
      start    = 1'b0;
      chk("busy_after_start", busy, 1);
      for (int k = 0; k < 2 * n_send; k++) begin
         int gap;
         gap = (gap_max == 0) ? 0 : $urandom_range(gap_max, 0);
         for (int g = 0; g < gap; g++) begin
            rx_valid = 1'b0;
            bank_sel = $urandom_range(1, 0);
            start    = abuse && ($urandom_range(2, 0) == 0);
            tick();
            start    = 1'b0;
         end
         rx_valid = 1'b1;
         rx_data  = b[k];
         // Restart attempt right after element 0 completes.
         start    = abuse && (k == 2);
         bank_sel = abuse ? ~bank : bank;
         tick();
         start    = 1'b0;
      end
      rx_valid = 1'b0;
      if (abuse && n_send == N) begin
         // Byte during FINISH, then during IDLE: both must be dropped.
         rx_valid = 1'b1;
         rx_data  = 8'hA5;
         tick();
         rx_data  = 8'h5A;
         tick();
         rx_valid = 1'b0;
      end
      tick();
      tick();
   endtask

   task automatic async_reset_check(input string tag);
      // Freeze the clock low, then assert reset between edges.
      @(negedge clk);
      #1;
      clk_en = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      chk({tag, "_we_A"},  we_A, 0);
      chk({tag, "_we_B"},  we_B, 0);
      chk({tag, "_addr"},  addr, 0);
      chk({tag, "_wdata"}, wdata, 0);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_done"},  done, 0);
      exp_q.delete();
      pend_done = 0;
      #5;
      reset  = 1'b0;
      #5;
      clk_en = 1'b1;
      tick();
   endtask

   logic [7:0] bytes_dir[2*N];
   logic [7:0] bytes_rnd[2*N];

   initial begin
      clk      = 1'b0;
      clk_en   = 1'b0;
      reset    = 1'b0;
      start    = 1'b0;
      bank_sel = 1'b0;
      rx_data  = '0;
      rx_valid = 1'b0;
      bytes_dir = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};

      // Reset with the clock stopped.
      #2;
      reset = 1'b1;
      #1;
      chk("por_we_A",  we_A, 0);
      chk("por_we_B",  we_B, 0);
      chk("por_addr",  addr, 0);
      chk("por_wdata", wdata, 0);
      chk("por_busy",  busy, 0);
      chk("por_done",  done, 0);
      #5;
      reset  = 1'b0;
      clk_en = 1'b1;
      tick();

      // Bytes without start: no writes (monitor flags any), busy stays low.
      for (int k = 0; k < 6; k++) begin
         rx_valid = 1'b1;
         rx_data  = 8'(k * 17);
         tick();
      end
      rx_valid = 1'b0;
      tick();
      chk("idle_busy_low", busy, 0);

      // Directed bank A, bank B (with bank_sel toggled), back-to-back.
      load(1'b1, bytes_dir, N, 2, 1'b0);
      load(1'b0, bytes_dir, N, 1, 1'b1);
      load(1'b1, bytes_dir, N, 0, 1'b0);
      // Protocol abuse with back-to-back bytes.
      load(1'b0, bytes_dir, N, 0, 1'b1);

      // Reset after two elements, then a complete fresh load.
      load(1'b1, bytes_dir, 2, 0, 1'b0);
      async_reset_check("midload_rst");
      load(1'b0, bytes_dir, N, 0, 1'b0);

      // Randomized loads.
      for (int r = 0; r < 12; r++) begin
         for (int k = 0; k < 2 * N; k++) bytes_rnd[k] = 8'($urandom);
         load(1'($urandom), bytes_rnd, N, $urandom_range(3, 0), 1'($urandom));
      end

      // Random partial load cut by reset, then a full load.
      for (int k = 0; k < 2 * N; k++) bytes_rnd[k] = 8'($urandom);
      load(1'($urandom), bytes_rnd, $urandom_range(N - 1, 1), 1, 1'b0);
      async_reset_check("rnd_rst");
      load(1'($urandom), bytes_rnd, N, 1, 1'b0);

      // Drain with a bounded wait.
      for (int t = 0; t < 20 && (exp_q.size() != 0 || pend_done); t++) tick();
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("done_not_pending", pend_done, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
